spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 263 ++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave
// SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first, oversampled by the system
// clock. A single-entry TX holding register feeds the transmit shifter at
// every word boundary. If the holding register is empty, the IDLE_TX word is
// sent instead and an underrun is flagged. Each completed received word is
// published on rx_data with a one-cycle rx_valid pulse.
//
// Ports
//   clk          system clock, all registers on its rising edge
//   rst          synchronous active-high reset
//   spi_sclk     SPI clock from the master (asynchronous to clk)
//   spi_csn      chip select from the master, active-low (asynchronous)
//   spi_mosi     serial data from the master (asynchronous)
//   spi_miso     serial data to the master
//   spi_miso_oe  MISO output enable, high only while a frame is active
//   tx_data      next word to transmit
//   tx_valid     tx_data is valid
//   tx_ready     TX holding register is empty
//   rx_data      last word received
//   rx_valid     one-cycle pulse, rx_data has just been updated
//   tx_underrun  one-cycle pulse, IDLE_TX was loaded because holding was empty
//   frame_err    one-cycle pulse, chip select rose in the middle of a word
//   busy         a frame is being shifted
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int unsigned       DATA_W  = 8,
    parameter logic [DATA_W-1:0] IDLE_TX = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2
    } state_e;

    // Synchronizer chains: bits [1:0] are the 2-flop synchronizer, bit [2]
    // is the extra copy used only for edge detection.
    logic [2:0]        sclk_q;
    logic [2:0]        csn_q;
    logic [1:0]        mosi_q;

    // After reset the synchronizers still hold their reset values for two
    // cycles. WAIT_IDLE must not trust csn until real pin samples reach the
    // second stage, otherwise a reset in the middle of a frame would see a
    // false idle followed by a false CS fall.
    logic [1:0]        settle_q,   settle_d;

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] shifter_q,  shifter_d;
    logic [DATA_W-1:0] holding_q,  holding_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] rx_data_q,  rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              frame_err_q, frame_err_d;
    logic              miso_q,     miso_d;
    logic              miso_oe_q,  miso_oe_d;
    logic              busy_q,     busy_d;

    logic              sclk_rise_s;
    logic              sclk_fall_s;
    logic              cs_fall_s;
    logic              cs_rise_s;
    logic              csn_sync_s;
    logic              mosi_sync_s;
    logic              settle_done_s;
    logic              word_load_s;

    assign csn_sync_s    = csn_q[1];
    assign mosi_sync_s   = mosi_q[1];
    assign sclk_rise_s   =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall_s   = ~sclk_q[1] &  sclk_q[2];
    assign cs_fall_s     = ~csn_q[1]  &  csn_q[2];
    assign cs_rise_s     =  csn_q[1]  & ~csn_q[2];
    assign settle_done_s = (settle_q == 2'd2);

    // Input synchronizers and edge-detect copies
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 3'b000;
            csn_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            csn_q  <= {csn_q[1:0],  spi_csn};
            mosi_q <= {mosi_q[0],   spi_mosi};
        end
    end

    // Next-state logic: frame FSM, shifters, holding register and pulses
    always_comb begin
        settle_d    = settle_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        shifter_d   = shifter_q;
        holding_d   = holding_q;
        tx_ready_d  = tx_ready_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        word_load_s = 1'b0;

        if (settle_done_s) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + 2'd1;
        end

        case (state_q)
            ST_WAIT_IDLE: begin
                if (settle_done_s && csn_sync_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d     = ST_SHIFT;
                    bit_cnt_d   = CNT_ZERO;
                    word_load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // CS rise wins over any sclk edge detected in the same cycle
                if (cs_rise_s) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = CNT_ZERO;
                    rx_shift_d  = {DATA_W{1'b0}};
                    frame_err_d = (bit_cnt_q != CNT_ZERO);
                end else if (sclk_rise_s) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_sync_s};
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d  = CNT_ZERO;
                        rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_sync_s};
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end else if (sclk_fall_s) begin
                    // bit_cnt back at zero after a falling edge means the
                    // previous word is complete: fetch the next one
                    if (bit_cnt_q == CNT_ZERO) begin
                        word_load_s = 1'b1;
                    end else begin
                        shifter_d = {shifter_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase

        // A word load always consumes the registered holding content
        if (word_load_s) begin
            if (!tx_ready_q) begin
                shifter_d  = holding_q;
                tx_ready_d = 1'b1;
            end else begin
                shifter_d  = IDLE_TX;
                underrun_d = 1'b1;
            end
        end else begin
            underrun_d = 1'b0;
        end

        // Holding capture. It can only fire when holding was empty, so it
        // never collides with a load that empties the holding register.
        if (tx_valid && tx_ready_q) begin
            holding_d  = tx_data;
            tx_ready_d = 1'b0;
        end else begin
            holding_d = holding_d;
        end

        if (state_d == ST_SHIFT) begin
            miso_d    = shifter_d[DATA_W-1];
            miso_oe_d = 1'b1;
            busy_d    = 1'b1;
        end else begin
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            busy_d    = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q    <= 2'd0;
            state_q     <= ST_WAIT_IDLE;
            bit_cnt_q   <= CNT_ZERO;
            rx_shift_q  <= {DATA_W{1'b0}};
            shifter_q   <= {DATA_W{1'b0}};
            holding_q   <= {DATA_W{1'b0}};
            tx_ready_q  <= 1'b1;
            rx_data_q   <= {DATA_W{1'b0}};
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            settle_q    <= settle_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            shifter_q   <= shifter_d;
            holding_q   <= holding_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_slave
// Directed bench for spi_slave: a mode-0 SPI master task, a holding-register
// writer and a pulse monitor. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int H = 8;  // SCLK half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         rx_cnt = 0;
    int         ur_cnt = 0;
    int         fe_cnt = 0;
    int         dbl_cnt = 0;
    logic [7:0] rx_prev = 8'h00;
    logic [7:0] rx_last = 8'h00;
    logic       rxv_q = 1'b0;
    logic       ur_q = 1'b0;
    logic       fe_q = 1'b0;
    logic       frame_oe = 1'b0;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    // Pulse monitor: counts pulses, logs received words, flags stretched pulses
    always @(negedge clk) begin
        rxv_q <= rx_valid;
        ur_q  <= tx_underrun;
        fe_q  <= frame_err;
        if (rx_valid) begin
            rx_cnt  <= rx_cnt + 1;
            rx_prev <= rx_last;
            rx_last <= rx_data;
        end
        if (tx_underrun) ur_cnt <= ur_cnt + 1;
        if (frame_err)   fe_cnt <= fe_cnt + 1;
        if ((rx_valid && rxv_q) || (tx_underrun && ur_q) || (frame_err && fe_q))
            dbl_cnt <= dbl_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Offer one word to the holding register and wait until it is taken
    task automatic write_tx(input logic [7:0] d);
        int n;
        tx_data  = d;
        tx_valid = 1'b1;
        for (n = 0; n < 200 && !tx_ready; n++) @(negedge clk);
        check_val("wr_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Mode-0 master: nbits MSB-first from mo[15:..]; MISO sampled at each rise.
    // The last falling sclk edge coincides with CS rising.
    task automatic spi_frame(input int nbits, input logic [15:0] mo, output logic [15:0] mi);
        mi = 16'h0000;
        @(negedge clk);
        spi_csn  = 1'b0;
        spi_mosi = mo[15];
        repeat (H) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            mi[15-b] = spi_miso;
            if (b == 0) frame_oe = spi_miso_oe;
            spi_sclk = 1'b1;
            repeat (H) @(negedge clk);
            if (b == nbits - 1) begin
                spi_sclk = 1'b0;
                spi_csn  = 1'b1;
            end else begin
                spi_sclk = 1'b0;
                spi_mosi = mo[14-b];
                repeat (H) @(negedge clk);
            end
        end
        repeat (2*H) @(negedge clk);
    endtask

    logic [15:0] mi;
    int          rx0, ur0, fe0;
    logic        oe_or;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_miso",     spi_miso,    1'b0);
        check_val("rst_oe",       spi_miso_oe, 1'b0);
        check_val("rst_tx_ready", tx_ready,    1'b1);
        check_val("rst_rx_data",  rx_data,     8'h00);
        check_val("rst_pulses",   {rx_valid, tx_underrun, frame_err}, 3'b000);
        check_val("rst_busy",     busy,        1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single word, holding loaded
        write_tx(8'hA5);
        check_val("a5_ready_low", tx_ready, 1'b0);
        rx0 = rx_cnt; ur0 = ur_cnt; fe0 = fe_cnt;
        spi_frame(8, 16'h3C00, mi);
        check_val("a5_miso",      mi[15:8], 8'hA5);
        check_val("a5_oe_frame",  frame_oe, 1'b1);
        check_val("a5_rx_data",   rx_data, 8'h3C);
        check_val("a5_rx_cnt",    rx_cnt - rx0, 1);
        check_val("a5_ready",     tx_ready, 1'b1);
        check_val("a5_underrun",  ur_cnt - ur0, 0);
        check_val("a5_frame_err", fe_cnt - fe0, 0);
        check_val("a5_oe_end",    spi_miso_oe, 1'b0);
        check_val("a5_busy_end",  busy, 1'b0);

        // Two words with nothing pending: idle pattern twice
        rx0 = rx_cnt; ur0 = ur_cnt;
        spi_frame(16, 16'h0102, mi);
        check_val("ur_miso",     mi, 16'hFFFF);
        check_val("ur_cnt",      ur_cnt - ur0, 2);
        check_val("ur_rx_cnt",   rx_cnt - rx0, 2);
        check_val("ur_rx_first", rx_prev, 8'h01);
        check_val("ur_rx_last",  rx_last, 8'h02);

        // Second word written during the first word
        write_tx(8'h11);
        ur0 = ur_cnt;
        fork
            spi_frame(16, 16'h5AA5, mi);
            begin
                repeat (30) @(negedge clk);
                write_tx(8'h22);
            end
        join
        check_val("b2b_miso",     mi, 16'h1122);
        check_val("b2b_underrun", ur_cnt - ur0, 0);
        check_val("b2b_rx",       rx_last, 8'hA5);

        // CS rises after 5 bits
        rx0 = rx_cnt; fe0 = fe_cnt; ur0 = ur_cnt;
        spi_frame(5, 16'hF800, mi);
        check_val("fe_cnt",      fe_cnt - fe0, 1);
        check_val("fe_rx_cnt",   rx_cnt - rx0, 0);
        check_val("fe_oe",       spi_miso_oe, 1'b0);
        check_val("fe_miso",     spi_miso, 1'b0);
        check_val("fe_underrun", ur_cnt - ur0, 1);
        write_tx(8'h5A);
        rx0 = rx_cnt; fe0 = fe_cnt;
        spi_frame(8, 16'hC300, mi);
        check_val("fe_next_miso", mi[15:8], 8'h5A);
        check_val("fe_next_rx",   rx_data, 8'hC3);
        check_val("fe_next_cnt",  rx_cnt - rx0, 1);
        check_val("fe_next_err",  fe_cnt - fe0, 0);

        // Reset in the middle of a frame with CS held low
        rx0 = rx_cnt;
        @(negedge clk);
        spi_csn  = 1'b0;
        spi_mosi = 1'b1;
        repeat (H) @(negedge clk);
        repeat (3) begin
            spi_sclk = 1'b1; repeat (H) @(negedge clk);
            spi_sclk = 1'b0; repeat (H) @(negedge clk);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        oe_or = 1'b0;
        repeat (5) begin
            spi_sclk = 1'b1;
            repeat (H) begin @(negedge clk); oe_or = oe_or | spi_miso_oe | busy; end
            spi_sclk = 1'b0;
            repeat (H) begin @(negedge clk); oe_or = oe_or | spi_miso_oe | busy; end
        end
        spi_csn = 1'b1;
        repeat (2*H) @(negedge clk);
        check_val("mrst_oe",      oe_or, 1'b0);
        check_val("mrst_rx_cnt",  rx_cnt - rx0, 0);
        check_val("mrst_rx_data", rx_data, 8'h00);
        check_val("mrst_ready",   tx_ready, 1'b1);
        write_tx(8'h96);
        rx0 = rx_cnt;
        spi_frame(8, 16'h6900, mi);
        check_val("mrst_miso",    mi[15:8], 8'h96);
        check_val("mrst_rx",      rx_data, 8'h69);
        check_val("mrst_rx_cnt2", rx_cnt - rx0, 1);

        // tx_valid held while holding is full with changing data
        write_tx(8'h77);
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = 8'h80 + 8'(i);
            @(negedge clk);
        end
        check_val("hold_ready", tx_ready, 1'b0);
        tx_valid = 1'b0;
        ur0 = ur_cnt;
        spi_frame(8, 16'h0000, mi);
        check_val("hold_miso",     mi[15:8], 8'h77);
        check_val("hold_underrun", ur_cnt - ur0, 0);
        check_val("hold_ready2",   tx_ready, 1'b1);

        check_val("pulse_width", dbl_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

endmodule
